// File: rtl/clock_gen_seq.sv
// ---------------------------------------------------------------------------
// clock_gen_seq
//
// Purpose:
//   Generates NUM_CH derived clock-enable channels from a single clock. Each
//   channel has a programmable divide value D. While running, the channel
//   produces a one-cycle enable pulse every D+1 cycles and a square wave that
//   toggles on each pulse. A lock sequencer (COUNT -> HOLD -> RUN) waits
//   LOCK_CYCLES cycles, raises locked, holds the downstream reset for
//   RST_HOLD more cycles and then lets the channels run. Every accepted
//   configuration write to a valid channel restarts that sequence.
//
// Optional feature:
//   Defining CLOCK_GEN_SEQ_PHASE_EN adds the cfg_phase input and a per-channel
//   phase register. A channel's counter then starts at min(phase, D) instead
//   of 0.
//
// Ports:
//   CLK        in   sole clock, rising edge
//   RST        in   asynchronous active-high reset
//   cfg_valid  in   configuration write request
//   cfg_ready  out  write can be accepted (high whenever RST is low)
//   cfg_ch     in   target channel index
//   cfg_div    in   new divide value D (period D+1 cycles)
//   cfg_phase  in   phase offset P (only with CLOCK_GEN_SEQ_PHASE_EN)
//   clk_en     out  per-channel single-cycle enable pulse
//   clk_tog    out  per-channel divided square wave
//   locked     out  divider configuration is stable
//   rst_out    out  active-high reset for downstream logic
// ---------------------------------------------------------------------------
module clock_gen_seq #(
  parameter int NUM_CH      = 2,
  parameter int DIV_WIDTH   = 8,
  parameter int DEFAULT_DIV = 1,
  parameter int LOCK_CYCLES = 16,
  parameter int RST_HOLD    = 4,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CH_W-1:0]      cfg_ch,
  input  logic [DIV_WIDTH-1:0] cfg_div,
`ifdef CLOCK_GEN_SEQ_PHASE_EN
  input  logic [DIV_WIDTH-1:0] cfg_phase,
`endif
  output logic [NUM_CH-1:0]    clk_en,
  output logic [NUM_CH-1:0]    clk_tog,
  output logic                 locked,
  output logic                 rst_out
);

  localparam logic [1:0] ST_COUNT = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  // One counter serves both COUNT and HOLD, so it is sized for the longer.
  localparam int LC_MAX = (LOCK_CYCLES > RST_HOLD) ? LOCK_CYCLES : RST_HOLD;
  localparam int LC_W   = $clog2(LC_MAX + 1);
  localparam logic [LC_W-1:0] LOCK_LAST = LC_W'(LOCK_CYCLES - 1);
  localparam logic [LC_W-1:0] HOLD_LAST = LC_W'(RST_HOLD - 1);

  logic [1:0]           state_q, state_d;
  logic [LC_W-1:0]      lockCnt_q, lockCnt_d;
  logic [DIV_WIDTH-1:0] div_q [NUM_CH];
  logic [DIV_WIDTH-1:0] div_d [NUM_CH];
  logic [DIV_WIDTH-1:0] cnt_q [NUM_CH];
  logic [DIV_WIDTH-1:0] cnt_d [NUM_CH];
  logic [DIV_WIDTH-1:0] startVal [NUM_CH];
  logic [NUM_CH-1:0]    tog_q, tog_d;
`ifdef CLOCK_GEN_SEQ_PHASE_EN
  logic [DIV_WIDTH-1:0] phase_q [NUM_CH];
  logic [DIV_WIDTH-1:0] phase_d [NUM_CH];
`endif

  logic              accept;
  logic              restart;
  logic              running;
  logic [NUM_CH-1:0] chSel;

  assign cfg_ready = ~RST;
  assign accept    = cfg_valid & cfg_ready;
  assign running   = (state_q == ST_RUN);
  assign locked    = (state_q == ST_HOLD) || (state_q == ST_RUN);
  assign rst_out   = ~running;
  assign clk_tog   = tog_q;

  // Decode the write target. An out-of-range index matches no channel, so
  // the handshake still completes but nothing changes and nothing restarts.
  always_comb begin
    chSel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      chSel[i] = accept && (cfg_ch == CH_W'(i));
    end
    restart = |chSel;
  end

  // Lock sequencer: COUNT for LOCK_CYCLES, HOLD for RST_HOLD, then RUN.
  // A valid configuration write sends it back to the start from any state.
  always_comb begin
    state_d   = state_q;
    lockCnt_d = lockCnt_q;
    case (state_q)
      ST_COUNT: begin
        if (lockCnt_q == LOCK_LAST) begin
          state_d   = ST_HOLD;
          lockCnt_d = '0;
        end else begin
          lockCnt_d = lockCnt_q + LC_W'(1);
        end
      end
      ST_HOLD: begin
        if (lockCnt_q == HOLD_LAST) begin
          state_d   = ST_RUN;
          lockCnt_d = '0;
        end else begin
          lockCnt_d = lockCnt_q + LC_W'(1);
        end
      end
      ST_RUN: begin
        lockCnt_d = '0;
      end
      default: begin
        state_d   = ST_COUNT;
        lockCnt_d = '0;
      end
    endcase
    if (restart) begin
      state_d   = ST_COUNT;
      lockCnt_d = '0;
    end
  end

  // Per-channel configuration registers and the counter start value. The
  // start value is taken from the next-cycle configuration so a counter
  // parked outside RUN already sits at its new start after a write.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      div_d[i] = chSel[i] ? cfg_div : div_q[i];
`ifdef CLOCK_GEN_SEQ_PHASE_EN
      phase_d[i]  = chSel[i] ? cfg_phase : phase_q[i];
      startVal[i] = (phase_d[i] < div_d[i]) ? phase_d[i] : div_d[i];
`else
      startVal[i] = '0;
`endif
    end
  end

  // Enable pulse is combinational on the terminal count and only in RUN.
  always_comb begin
    clk_en = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      clk_en[i] = running && (cnt_q[i] == div_q[i]);
    end
  end

  // Channel counters run only while RUN persists; any other cycle (including
  // the one that captures a restart) parks the counter and clears the toggle.
  always_comb begin
    tog_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (running && !restart) begin
        cnt_d[i] = clk_en[i] ? '0 : cnt_q[i] + DIV_WIDTH'(1);
        tog_d[i] = tog_q[i] ^ clk_en[i];
      end else begin
        cnt_d[i] = startVal[i];
        tog_d[i] = 1'b0;
      end
    end
  end

  // State registers with asynchronous reset back to the COUNT start point.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_COUNT;
      lockCnt_q <= '0;
      tog_q     <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i] <= DIV_WIDTH'(DEFAULT_DIV);
        cnt_q[i] <= '0;
`ifdef CLOCK_GEN_SEQ_PHASE_EN
        phase_q[i] <= '0;
`endif
      end
    end else begin
      state_q   <= state_d;
      lockCnt_q <= lockCnt_d;
      tog_q     <= tog_d;
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i] <= div_d[i];
        cnt_q[i] <= cnt_d[i];
`ifdef CLOCK_GEN_SEQ_PHASE_EN
        phase_q[i] <= phase_d[i];
`endif
      end
    end
  end

endmodule

// File: tb/tb_clock_gen_seq.sv
// ---------------------------------------------------------------------------
// tb_clock_gen_seq
//
// Scoreboard bench for clock_gen_seq. Each scenario updates a small
// arithmetic model of the channel configuration, pushes the expected
// per-cycle outputs into a queue and pops them as the DUT advances.
// Cycle index k counts edges since the last point where the sequencer sat
// at the start of COUNT; RUN begins at k = LOCK_CYCLES + RST_HOLD.
// ---------------------------------------------------------------------------
module tb_clock_gen_seq;

  localparam int NUM_CH      = 3;
  localparam int DIV_WIDTH   = 8;
  localparam int DEFAULT_DIV = 1;
  localparam int LOCK_CYCLES = 16;
  localparam int RST_HOLD    = 4;
  localparam int CH_W        = 2;
  localparam int RUN_K       = LOCK_CYCLES + RST_HOLD;

  logic                 CLK = 1'b0;
  logic                 RST = 1'b1;
  logic                 cfg_valid = 1'b0;
  logic                 cfg_ready;
  logic [CH_W-1:0]      cfg_ch = '0;
  logic [DIV_WIDTH-1:0] cfg_div = '0;
`ifdef CLOCK_GEN_SEQ_PHASE_EN
  logic [DIV_WIDTH-1:0] cfg_phase = '0;
`endif
  logic [NUM_CH-1:0]    clk_en;
  logic [NUM_CH-1:0]    clk_tog;
  logic                 locked;
  logic                 rst_out;

  typedef struct packed {
    logic              locked;
    logic              rstOut;
    logic [NUM_CH-1:0] en;
    logic [NUM_CH-1:0] tog;
  } obsT;

  localparam obsT RESET_OBS = '{locked: 1'b0, rstOut: 1'b1, en: '0, tog: '0};

  obsT expQ[$];
  obsT expV;
  obsT gotV;
  int  vecCount = 0;
  int  missCount = 0;
  int  seqK = 0;
  int  divModel [NUM_CH];
  int  startModel [NUM_CH];

  clock_gen_seq #(
    .NUM_CH      (NUM_CH),
    .DIV_WIDTH   (DIV_WIDTH),
    .DEFAULT_DIV (DEFAULT_DIV),
    .LOCK_CYCLES (LOCK_CYCLES),
    .RST_HOLD    (RST_HOLD)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
`ifdef CLOCK_GEN_SEQ_PHASE_EN
    .cfg_phase (cfg_phase),
`endif
    .clk_en    (clk_en),
    .clk_tog   (clk_tog),
    .locked    (locked),
    .rst_out   (rst_out)
  );

  always #5 CLK = ~CLK;

  // Closed-form expectation: in RUN cycle r a channel's count is
  // (start + r) mod (D+1); the square wave has seen (start + r) / (D+1)
  // pulses so far.
  function automatic obsT expAt(int k);
    obsT e;
    int r;
    int p;
    e.locked = (k >= LOCK_CYCLES);
    e.rstOut = (k < RUN_K);
    e.en     = '0;
    e.tog    = '0;
    if (k >= RUN_K) begin
      r = k - RUN_K;
      for (int i = 0; i < NUM_CH; i++) begin
        p = divModel[i] + 1;
        e.en[i]  = ((startModel[i] + r) % p) == divModel[i];
        e.tog[i] = (((startModel[i] + r) / p) % 2) == 1;
      end
    end
    return e;
  endfunction

  function automatic obsT observed();
    obsT o;
    o.locked = locked;
    o.rstOut = rst_out;
    o.en     = clk_en;
    o.tog    = clk_tog;
    return o;
  endfunction

  task automatic modelDefaults();
    for (int i = 0; i < NUM_CH; i++) begin
      divModel[i]   = DEFAULT_DIV;
      startModel[i] = 0;
    end
  endtask

  task automatic pushWindow(input int n);
    for (int j = 1; j <= n; j++) begin
      expQ.push_back(expAt(seqK + j));
    end
  endtask

  // Drives one configuration beat across one clock edge and updates the
  // model. Returns #1 after that edge with cfg_valid low.
  task automatic applyStimulus(input int ch, input int div, input int phase);
    cfg_valid = 1'b1;
    cfg_ch    = CH_W'(ch);
    cfg_div   = DIV_WIDTH'(div);
`ifdef CLOCK_GEN_SEQ_PHASE_EN
    cfg_phase = DIV_WIDTH'(phase);
`endif
    @(posedge CLK);
    #1;
    cfg_valid = 1'b0;
    if (ch < NUM_CH) begin
      divModel[ch] = div;
`ifdef CLOCK_GEN_SEQ_PHASE_EN
      startModel[ch] = (phase < div) ? phase : div;
`else
      startModel[ch] = 0;
`endif
      seqK = 0;
    end else begin
      seqK = seqK + 1;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    vecCount++;
    if (cfg_ready !== 1'b0) begin
      missCount++;
      $display("FAIL reset_ready got=%b expected=0", cfg_ready);
    end
    gotV = observed();
    vecCount++;
    if (gotV !== RESET_OBS) begin
      missCount++;
      $display("FAIL reset_outputs got=%b expected=%b", gotV, RESET_OBS);
    end
    RST = 1'b0;
    modelDefaults();
    seqK = 0;
    #1;
    vecCount++;
    if (cfg_ready !== 1'b1) begin
      missCount++;
      $display("FAIL release_ready got=%b expected=1", cfg_ready);
    end
    pushWindow(RUN_K + 10);
    while (expQ.size() > 0) begin
      @(posedge CLK);
      #1;
      seqK++;
      expV = expQ.pop_front();
      gotV = observed();
      vecCount++;
      if (gotV !== expV) begin
        missCount++;
        $display("FAIL lock_seq k=%0d got=%b expected=%b", seqK, gotV, expV);
      end
    end
  endtask

  task automatic test_divide();
    vecCount++;
    if (cfg_ready !== 1'b1) begin
      missCount++;
      $display("FAIL div_ready got=%b expected=1", cfg_ready);
    end
    applyStimulus(0, 3, 0);
    gotV = observed();
    expV = expAt(seqK);
    vecCount++;
    if (gotV !== expV) begin
      missCount++;
      $display("FAIL div_unlock got=%b expected=%b", gotV, expV);
    end
    pushWindow(RUN_K + 17);
    while (expQ.size() > 0) begin
      @(posedge CLK);
      #1;
      seqK++;
      expV = expQ.pop_front();
      gotV = observed();
      vecCount++;
      if (gotV !== expV) begin
        missCount++;
        $display("FAIL div3 k=%0d got=%b expected=%b", seqK, gotV, expV);
      end
    end
  endtask

  task automatic test_invalid_ch();
    applyStimulus(3, 7, 0);
    gotV = observed();
    expV = expAt(seqK);
    vecCount++;
    if (gotV !== expV) begin
      missCount++;
      $display("FAIL bad_ch_handshake k=%0d got=%b expected=%b", seqK, gotV, expV);
    end
    pushWindow(12);
    while (expQ.size() > 0) begin
      @(posedge CLK);
      #1;
      seqK++;
      expV = expQ.pop_front();
      gotV = observed();
      vecCount++;
      if (gotV !== expV) begin
        missCount++;
        $display("FAIL bad_ch_run k=%0d got=%b expected=%b", seqK, gotV, expV);
      end
    end
  endtask

  task automatic test_d_zero();
    applyStimulus(1, 0, 0);
    pushWindow(RUN_K + 8);
    while (expQ.size() > 0) begin
      @(posedge CLK);
      #1;
      seqK++;
      expV = expQ.pop_front();
      gotV = observed();
      vecCount++;
      if (gotV !== expV) begin
        missCount++;
        $display("FAIL d_zero k=%0d got=%b expected=%b", seqK, gotV, expV);
      end
    end
  endtask

  task automatic test_back_to_back();
    applyStimulus(2, 2, 0);
    gotV = observed();
    expV = expAt(seqK);
    vecCount++;
    if (gotV !== expV) begin
      missCount++;
      $display("FAIL b2b_first got=%b expected=%b", gotV, expV);
    end
    applyStimulus(0, 5, 0);
    pushWindow(RUN_K + 14);
    while (expQ.size() > 0) begin
      @(posedge CLK);
      #1;
      seqK++;
      expV = expQ.pop_front();
      gotV = observed();
      vecCount++;
      if (gotV !== expV) begin
        missCount++;
        $display("FAIL b2b k=%0d got=%b expected=%b", seqK, gotV, expV);
      end
    end
  endtask

  task automatic test_async_reset();
    @(posedge CLK);
    #3;
    RST = 1'b1;
    #1;
    gotV = observed();
    vecCount++;
    if (gotV !== RESET_OBS) begin
      missCount++;
      $display("FAIL async_rst_outputs got=%b expected=%b", gotV, RESET_OBS);
    end
    vecCount++;
    if (cfg_ready !== 1'b0) begin
      missCount++;
      $display("FAIL async_rst_ready got=%b expected=0", cfg_ready);
    end
    @(posedge CLK);
    #1;
    RST = 1'b0;
    modelDefaults();
    seqK = 0;
    pushWindow(RUN_K + 8);
    while (expQ.size() > 0) begin
      @(posedge CLK);
      #1;
      seqK++;
      expV = expQ.pop_front();
      gotV = observed();
      vecCount++;
      if (gotV !== expV) begin
        missCount++;
        $display("FAIL post_rst k=%0d got=%b expected=%b", seqK, gotV, expV);
      end
    end
  endtask

`ifdef CLOCK_GEN_SEQ_PHASE_EN
  task automatic test_phase();
    applyStimulus(0, 3, 2);
    pushWindow(RUN_K + 8);
    while (expQ.size() > 0) begin
      @(posedge CLK);
      #1;
      seqK++;
      expV = expQ.pop_front();
      gotV = observed();
      vecCount++;
      if (gotV !== expV) begin
        missCount++;
        $display("FAIL phase2 k=%0d got=%b expected=%b", seqK, gotV, expV);
      end
    end
    applyStimulus(0, 3, 9);
    pushWindow(RUN_K + 8);
    while (expQ.size() > 0) begin
      @(posedge CLK);
      #1;
      seqK++;
      expV = expQ.pop_front();
      gotV = observed();
      vecCount++;
      if (gotV !== expV) begin
        missCount++;
        $display("FAIL phase_clamp k=%0d got=%b expected=%b", seqK, gotV, expV);
      end
    end
  endtask
`endif

  // Scenarios run in order; each leaves the block in RUN for the next one.
  initial begin
    test_reset();
    test_divide();
    test_invalid_ch();
    test_d_zero();
    test_back_to_back();
    test_async_reset();
`ifdef CLOCK_GEN_SEQ_PHASE_EN
    test_phase();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
